// File: rtl/csa_sum_accumulator.sv
`timescale 1ns / 1ps
// csa_sum_accumulator
// Sums COUNT consecutive accepted results from the carry-save adder pipeline
// into an ACC_WIDTH accumulator and presents each block total on a
// valid/ready output. The upstream pipeline cannot stall, so beats offered
// while the block is not ready are discarded and recorded in a sticky flag.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous reset, active low
//   clear        synchronous flush, active high (wins over everything but reset)
//   in_valid     in_sum carries a valid result
//   in_sum       unsigned pipeline sum, WIDTH bits
//   in_ready     beat accepted this cycle when in_valid is also high (combinational)
//   out_valid    block total available (registered)
//   out_ready    downstream takes the total
//   out_acc      running / presented total, ACC_WIDTH bits
//   out_count    beats accumulated in the current block
//   out_overflow carry lost out of ACC_WIDTH during the block
//   dropped      sticky: a beat was lost while in_ready was low
//   busy         block is not idle
module csa_sum_accumulator #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned COUNT     = 8,
  parameter int unsigned ACC_WIDTH = 40,
  parameter int unsigned CNT_W     = $clog2(COUNT + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     in_sum,
  output logic                 in_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_acc,
  output logic [CNT_W-1:0]     out_count,
  output logic                 out_overflow,
  output logic                 dropped,
  output logic                 busy
);

  typedef enum logic [1:0] {
    StIdle,
    StAccum,
    StHold
  } state_e;

  localparam logic [CNT_W-1:0] CountLast  = CNT_W'(COUNT);
  localparam bit               SingleBeat = (COUNT == 1);

  state_e               r_state;
  logic [ACC_WIDTH-1:0] r_acc;
  logic [CNT_W-1:0]     r_count;
  logic                 r_ovf;
  logic                 r_dropped;
  logic                 r_out_valid;

  logic                 w_accept;
  logic [ACC_WIDTH-1:0] w_in_ext;
  logic [ACC_WIDTH:0]   w_sum;
  logic [CNT_W-1:0]     w_count_inc;
  logic                 w_last;

  // In HOLD a new beat can only enter in the same cycle the total leaves.
  assign in_ready    = (r_state != StHold) || out_ready;
  assign w_accept    = in_valid && in_ready;
  assign w_in_ext    = ACC_WIDTH'(in_sum);
  // One extra bit captures the carry out of the accumulator.
  assign w_sum       = {1'b0, r_acc} + {1'b0, w_in_ext};
  assign w_count_inc = r_count + CNT_W'(1);
  assign w_last      = (w_count_inc == CountLast);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= StIdle;
      r_acc       <= '0;
      r_count     <= '0;
      r_ovf       <= 1'b0;
      r_dropped   <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (clear) begin
      r_state     <= StIdle;
      r_acc       <= '0;
      r_count     <= '0;
      r_ovf       <= 1'b0;
      r_dropped   <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      if (in_valid && !in_ready) begin
        r_dropped <= 1'b1;
      end
      unique case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_acc       <= w_in_ext;
            r_count     <= CNT_W'(1);
            r_ovf       <= 1'b0;
            r_state     <= SingleBeat ? StHold : StAccum;
            r_out_valid <= SingleBeat;
          end
        end
        StAccum: begin
          if (w_accept) begin
            r_acc   <= w_sum[ACC_WIDTH-1:0];
            r_count <= w_count_inc;
            r_ovf   <= r_ovf | w_sum[ACC_WIDTH];
            if (w_last) begin
              r_state     <= StHold;
              r_out_valid <= 1'b1;
            end
          end
        end
        StHold: begin
          if (out_ready) begin
            if (w_accept) begin
              // Hand-off and first beat of the next block in one cycle.
              r_acc       <= w_in_ext;
              r_count     <= CNT_W'(1);
              r_ovf       <= 1'b0;
              r_state     <= SingleBeat ? StHold : StAccum;
              r_out_valid <= SingleBeat;
            end else begin
              r_acc       <= '0;
              r_count     <= '0;
              r_ovf       <= 1'b0;
              r_state     <= StIdle;
              r_out_valid <= 1'b0;
            end
          end
        end
        default: begin
          r_state     <= StIdle;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid    = r_out_valid;
  assign out_acc      = r_acc;
  assign out_count    = r_count;
  assign out_overflow = r_ovf;
  assign dropped      = r_dropped;
  assign busy         = (r_state != StIdle);

endmodule

// File: tb/tb_csa_sum_accumulator.sv
`timescale 1ns / 1ps
// Bench for csa_sum_accumulator. Two instances share one stimulus stream:
// A uses the defaults (COUNT=8, ACC_WIDTH=40), B uses COUNT=4, ACC_WIDTH=33
// so that accumulator overflow is reachable.
module tb_csa_sum_accumulator;

  localparam int unsigned CntA = 8;
  localparam int unsigned AccA = 40;
  localparam int unsigned CntB = 4;
  localparam int unsigned AccB = 33;

  logic        clk       = 1'b0;
  logic        reset     = 1'b0;
  logic        clear     = 1'b0;
  logic        in_valid  = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_sum    = '0;

  always #5 clk = ~clk;

  logic            a_in_ready, a_out_valid, a_out_ovf, a_dropped, a_busy;
  logic [AccA-1:0] a_out_acc;
  logic [3:0]      a_out_count;
  logic            b_in_ready, b_out_valid, b_out_ovf, b_dropped, b_busy;
  logic [AccB-1:0] b_out_acc;
  logic [2:0]      b_out_count;

  csa_sum_accumulator #(.WIDTH(32), .COUNT(CntA), .ACC_WIDTH(AccA)) dut_a (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_sum(in_sum),
    .in_ready(a_in_ready), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_acc(a_out_acc), .out_count(a_out_count), .out_overflow(a_out_ovf),
    .dropped(a_dropped), .busy(a_busy)
  );

  csa_sum_accumulator #(.WIDTH(32), .COUNT(CntB), .ACC_WIDTH(AccB)) dut_b (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_sum(in_sum),
    .in_ready(b_in_ready), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_acc(b_out_acc), .out_count(b_out_count), .out_overflow(b_out_ovf),
    .dropped(b_dropped), .busy(b_busy)
  );

  typedef struct {
    logic [63:0] acc;
    logic        ovf;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: a block is simply the list of accepted beats; a completed
  // block waits as "pending" until the consumer takes it.
  longint unsigned m_sum [2];
  int unsigned     m_n   [2];
  bit              m_pend[2];
  bit              m_drop[2];

  task automatic check(string name, logic [63:0] act, logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic bit m_ready(int i);
    return !m_pend[i] || out_ready;
  endfunction

  task automatic model_reset_one(int i);
    if (m_pend[i]) begin
      if (i == 0) void'(q_a.pop_back());
      else        void'(q_b.pop_back());
    end
    m_sum[i]  = 0;
    m_n[i]    = 0;
    m_pend[i] = 1'b0;
    m_drop[i] = 1'b0;
  endtask

  task automatic model_reset();
    model_reset_one(0);
    model_reset_one(1);
  endtask

  task automatic model_step(int i);
    int unsigned cnt  = (i == 0) ? CntA : CntB;
    int unsigned accw = (i == 0) ? AccA : AccB;
    bit   rdy;
    exp_t e;
    if (clear) begin
      model_reset_one(i);
      return;
    end
    rdy = m_ready(i);
    if (in_valid && !rdy) m_drop[i] = 1'b1;
    if (m_pend[i] && out_ready) m_pend[i] = 1'b0;
    if (in_valid && rdy) begin
      m_sum[i] += 64'(in_sum);
      m_n[i]++;
      if (m_n[i] == cnt) begin
        e.acc = m_sum[i] & ((64'd1 << accw) - 64'd1);
        e.ovf = (m_sum[i] >> accw) != 0;
        if (i == 0) q_a.push_back(e);
        else        q_b.push_back(e);
        m_pend[i] = 1'b1;
        m_n[i]    = 0;
        m_sum[i]  = 0;
      end
    end
  endtask

  // One clock cycle of stimulus; inputs change 1ns after the rising edge.
  task automatic beat(bit v, logic [31:0] s, bit ordy, bit clr);
    @(posedge clk);
    #1;
    in_valid  = v;
    in_sum    = s;
    out_ready = ordy;
    clear     = clr;
    #1;
    check("in_ready_a", 64'(a_in_ready), 64'(m_ready(0)));
    check("in_ready_b", 64'(b_in_ready), 64'(m_ready(1)));
    check("dropped_a", 64'(a_dropped), 64'(m_drop[0]));
    check("dropped_b", 64'(b_dropped), 64'(m_drop[1]));
    model_step(0);
    model_step(1);
  endtask

  // Monitors: a total is handed off whenever valid and ready meet at an edge.
  always @(negedge clk) begin : mon_a
    exp_t e;
    if (reset && !clear && a_out_valid && out_ready) begin
      if (q_a.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL total_a: unexpected total %0h, none expected", a_out_acc);
      end else begin
        e = q_a.pop_front();
        check("total_acc_a", 64'(a_out_acc), e.acc);
        check("total_cnt_a", 64'(a_out_count), 64'(CntA));
        check("total_ovf_a", 64'(a_out_ovf), 64'(e.ovf));
      end
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (reset && !clear && b_out_valid && out_ready) begin
      if (q_b.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL total_b: unexpected total %0h, none expected", b_out_acc);
      end else begin
        e = q_b.pop_front();
        check("total_acc_b", 64'(b_out_acc), e.acc);
        check("total_cnt_b", 64'(b_out_count), 64'(CntB));
        check("total_ovf_b", 64'(b_out_ovf), 64'(e.ovf));
      end
    end
  end

  initial begin : watchdog
    #500000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : stim
    bit          v, ordy, clr;
    logic [31:0] s;
    model_reset();

    // Reset values, with a beat offered during reset.
    reset    = 1'b0;
    in_valid = 1'b1;
    in_sum   = 32'd5;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 64'(a_out_valid), 64'd0);
    check("rst_acc", 64'(a_out_acc), 64'd0);
    check("rst_count", 64'(a_out_count), 64'd0);
    check("rst_ovf", 64'(a_out_ovf), 64'd0);
    check("rst_dropped", 64'(a_dropped), 64'd0);
    check("rst_busy", 64'(a_busy), 64'd0);
    check("rst_in_ready", 64'(a_in_ready), 64'd1);
    check("rst_busy_b", 64'(b_busy), 64'd0);
    reset    = 1'b1;
    in_valid = 1'b0;

    // Basic blocks back to back: 1..8 then 9..16.
    for (int k = 1; k <= 16; k++) begin
      beat(1'b1, 32'(k), 1'b1, 1'b0);
      if (k == 9) begin
        check("blk1_valid", 64'(a_out_valid), 64'd1);
        check("blk1_acc", 64'(a_out_acc), 64'd36);
        check("blk1_count", 64'(a_out_count), 64'd8);
      end
      if (k == 10) check("blk1_one_cycle", 64'(a_out_valid), 64'd0);
    end
    beat(1'b0, 32'd0, 1'b1, 1'b0);
    check("blk2_acc", 64'(a_out_acc), 64'd100);
    check("blk2_valid", 64'(a_out_valid), 64'd1);

    // Overflow on the narrow instance.
    for (int k = 0; k < 4; k++) beat(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      beat(1'b1, 32'd1, 1'b1, 1'b0);
      if (k == 0) begin
        check("ovf_acc_b", 64'(b_out_acc), 64'h1_FFFF_FFFC);
        check("ovf_flag_b", 64'(b_out_ovf), 64'd1);
      end
    end
    beat(1'b0, 32'd0, 1'b1, 1'b0);
    check("ovf_next_acc_b", 64'(b_out_acc), 64'd4);
    check("ovf_next_flag_b", 64'(b_out_ovf), 64'd0);

    // Backpressure and drop.
    for (int k = 1; k <= 8; k++) beat(1'b1, 32'(k), 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      beat(1'b1, 32'd5, 1'b0, 1'b0);
      check("hold_acc", 64'(a_out_acc), 64'd36);
      check("hold_not_ready", 64'(a_in_ready), 64'd0);
      if (k > 0) check("hold_dropped", 64'(a_dropped), 64'd1);
    end
    beat(1'b1, 32'd7, 1'b1, 1'b0);
    beat(1'b0, 32'd0, 1'b1, 1'b0);
    check("restart_acc", 64'(a_out_acc), 64'd7);
    check("restart_count", 64'(a_out_count), 64'd1);

    // Asynchronous reset between clock edges.
    for (int k = 0; k < 5; k++) beat(1'b1, 32'd10, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("pre_rst_count", 64'(a_out_count), 64'd6);
    #2;
    reset = 1'b0;
    #1;
    check("arst_count", 64'(a_out_count), 64'd0);
    check("arst_acc", 64'(a_out_acc), 64'd0);
    check("arst_busy", 64'(a_busy), 64'd0);
    check("arst_busy_b", 64'(b_busy), 64'd0);
    reset = 1'b1;
    model_reset();
    for (int k = 0; k < 8; k++) beat(1'b1, 32'd2, 1'b1, 1'b0);
    beat(1'b0, 32'd0, 1'b1, 1'b0);
    check("post_rst_acc", 64'(a_out_acc), 64'd16);

    // clear during HOLD together with a beat.
    for (int k = 1; k <= 8; k++) beat(1'b1, 32'(k), 1'b0, 1'b0);
    beat(1'b1, 32'd99, 1'b1, 1'b1);
    beat(1'b0, 32'd0, 1'b1, 1'b0);
    check("clr_valid", 64'(a_out_valid), 64'd0);
    check("clr_dropped", 64'(a_dropped), 64'd0);
    check("clr_busy", 64'(a_busy), 64'd0);
    check("clr_count", 64'(a_out_count), 64'd0);
    check("clr_dropped_b", 64'(b_dropped), 64'd0);
    for (int k = 0; k < 8; k++) beat(1'b1, 32'd3, 1'b1, 1'b0);
    beat(1'b0, 32'd0, 1'b1, 1'b0);
    check("clr_next_acc", 64'(a_out_acc), 64'd24);

    // Random traffic with backpressure and occasional flushes.
    for (int k = 0; k < 400; k++) begin
      v    = ($urandom_range(0, 9) < 7);
      s    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFF - 32'($urandom_range(0, 15)))
                                         : 32'($urandom);
      ordy = ($urandom_range(0, 9) < 7);
      clr  = ($urandom_range(0, 49) == 0);
      beat(v, s, ordy, clr);
    end

    // Drain pending totals.
    repeat (6) beat(1'b0, 32'd0, 1'b1, 1'b0);
    @(negedge clk);
    #1;
    check("drain_q_a", 64'(q_a.size()), 64'd0);
    check("drain_q_b", 64'(q_b.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
